alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
Round-robin arbiter and sequencer that shares one combinational 6-bit two's-complement ALU core between N_REQ requesters. It accepts per-requester operand/opcode requests, grants one requester at a time, and drives the ALU operand/opcode registers. It captures the ALU result and error flag and returns them with a one-cycle done pulse. It sits between the requesting blocks (switch front-end, test sequencer, etc.) and the ALU core feeding the 7-segment display path.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 6, operand/result width, two's complement.
- OP_W, 3, opcode width.

Ports:
- clk_100MHz  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req  in  N_REQ  per-requester request level.
- req_a  in  N_REQ*WIDTH  operand A of requester i at [i*WIDTH +: WIDTH].
- req_b  in  N_REQ*WIDTH  operand B, same packing.
- req_op  in  N_REQ*OP_W  opcode of requester i at [i*OP_W +: OP_W].
- gnt  out  N_REQ  one-hot grant, all-zero when idle.
- done  out  1  one-cycle pulse, result/err valid for granted requester.
- result  out  WIDTH  captured ALU result.
- err  out  1  captured ALU overflow/invalid-op flag.
- busy  out  1  high whenever state != IDLE.
- alu_a, alu_b  out  WIDTH  registered operands to ALU core.
- alu_op  out  OP_W  registered opcode to ALU core.
- alu_result  in  WIDTH  ALU core combinational result.
- alu_err  in  1  ALU core combinational error.
- op_count  out  8  completed operations, wraps 255->0.
- err_count  out  8  completed operations with err=1, saturates at 255.

Behaviour:
- Reset values: state IDLE, gnt=0, done=0, result=0, err=0, busy=0, alu_a/alu_b/alu_op=0, pointer=0, op_count=0, err_count=0.
- FSM states: IDLE, EXEC, DONE.
- IDLE, no req bit set: stay.
- IDLE, any req bit set: winner = first set bit searching upward from pointer, modulo N_REQ.
  - On that edge: gnt<=onehot(winner); alu_a/alu_b/alu_op<=winner's fields; -> EXEC.
- EXEC: result<=alu_result; err<=alu_err; done<=1; op_count++; err_count++ if alu_err and <255; -> DONE.
- DONE (done=1 visible this cycle, gnt held): next edge done<=0, gnt<=0, pointer<=(winner+1) mod N_REQ; -> IDLE.
- Latency: req sampled at edge k gives gnt at k, done high between k+1 and k+2, gnt low after k+2. Next arbitration is at edge k+3. Throughput is 1 op / 3 cycles.
- Operands are sampled only at the grant edge. Later changes on req_a/req_b/req_op/req are ignored until the next grant.
- Dropping req during EXEC/DONE does not abort; the operation completes and done still pulses.
- Requester keeping req high is re-eligible at the next IDLE. Round-robin guarantees any continuously requesting requester is served within N_REQ grants.
- Simultaneous requests: only the winner is granted; others wait, with no loss of request state (level-sensitive).
- alu_a/alu_b/alu_op hold their last values after completion; they are not cleared.
- result/err hold until the next EXEC capture.
- Reset asserted mid-operation: everything returns to reset values asynchronously. No done pulse, counters cleared. Arbitration restarts from pointer 0 after reset release.
- Pointer wrap: winner N_REQ-1 sets pointer 0.

Test Plan:
- Single request, bench ALU core wired to alu_*: req[0] with a=6'b001001, b=6'b001010, op=000 -> gnt=0001 at edge k, done pulse at k+1, result=6'b010011 (19), err=0, op_count=1.
- Overflow: req[2] with a=6'b010000, b=6'b010111, op=000 -> done with err=1, err_count=1. Then req[2] with a=6'b111100, b=6'b001001, op=001 -> result=6'b110011 (-13), err=0, op_count=2.
- Fairness: req=1111 held continuously from reset -> grant order 0,1,2,3,0, each grant exactly 2 cycles, done pulses every 3 cycles.
- Pointer skip/wrap: after serving requester 3, assert req=0101 -> requester 0 granted first, then 2. With pointer=1 and req=0001 -> requester 0 granted.
- Operand stability and withdrawal: change req_a of the granted requester and drop its req one cycle after grant -> result still reflects operands at grant edge, done still pulses.
- Reset mid-op plus counter limits: assert reset during EXEC -> gnt, done, busy, counters immediately 0, state IDLE. Force 256 completed ops -> op_count wraps to 0. Force 260 error ops -> err_count holds 255.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Bus bundle between the requesters, the round-robin ALU arbiter and the
// shared combinational ALU core. The arbiter connects through the slave
// modport; requesters and the ALU core connect through the master modport.
interface alu_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 6,
  parameter int OP_W  = 3
);
  // requester side
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ*OP_W-1:0]  req_op;
  logic [N_REQ-1:0]       gnt;
  logic                   done;
  logic [WIDTH-1:0]       result;
  logic                   err;
  logic                   busy;
  logic [7:0]             op_count;
  logic [7:0]             err_count;
  // ALU core side
  logic [WIDTH-1:0]       alu_a;
  logic [WIDTH-1:0]       alu_b;
  logic [OP_W-1:0]        alu_op;
  logic [WIDTH-1:0]       alu_result;
  logic                   alu_err;

  modport slave (
    input  req, req_a, req_b, req_op, alu_result, alu_err,
    output gnt, done, result, err, busy, op_count, err_count,
           alu_a, alu_b, alu_op
  );

  modport master (
    output req, req_a, req_b, req_op, alu_result, alu_err,
    input  gnt, done, result, err, busy, op_count, err_count,
           alu_a, alu_b, alu_op
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU core between
// N_REQ requesters. One operation takes three cycles: grant (operands are
// latched into the ALU registers), execute (ALU output captured, done raised),
// and done (grant held while done is visible, then released).
module alu_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 6,
  parameter int OP_W  = 3
) (
  input  logic          clk_100MHz,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_r;
  logic [PTR_W-1:0] ptr_r;
  logic [PTR_W-1:0] win_r;
  logic [N_REQ-1:0] gnt_r;
  logic             done_r;
  logic             busy_r;
  logic [WIDTH-1:0] result_r;
  logic             err_r;
  logic [WIDTH-1:0] alu_a_r;
  logic [WIDTH-1:0] alu_b_r;
  logic [OP_W-1:0]  alu_op_r;
  logic [7:0]       op_count_r;
  logic [7:0]       err_count_r;

  logic             found_s;
  logic [PTR_W-1:0] idx_s;
  logic [PTR_W-1:0] winner_s;
  logic [N_REQ-1:0] gnt_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic [OP_W-1:0]  sel_op_s;
  logic [PTR_W-1:0] ptr_next_s;

  // Round-robin search: first asserted request at or above the pointer, wrapping.
  always_comb begin
    found_s  = 1'b0;
    idx_s    = {PTR_W{1'b0}};
    winner_s = {PTR_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      idx_s = PTR_W'((int'(ptr_r) + i) % N_REQ);
      if (!found_s && bus.req[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Select the winner's operand fields and build its one-hot grant.
  always_comb begin
    sel_a_s  = {WIDTH{1'b0}};
    sel_b_s  = {WIDTH{1'b0}};
    sel_op_s = {OP_W{1'b0}};
    gnt_s    = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (winner_s == PTR_W'(i)) begin
        sel_a_s  = bus.req_a[i*WIDTH +: WIDTH];
        sel_b_s  = bus.req_b[i*WIDTH +: WIDTH];
        sel_op_s = bus.req_op[i*OP_W +: OP_W];
        gnt_s[i] = 1'b1;
      end else begin
        gnt_s[i] = 1'b0;
      end
    end
  end

  // Pointer moves one past the last winner, wrapping at N_REQ-1.
  always_comb begin
    if (win_r == PTR_W'(N_REQ - 1)) begin
      ptr_next_s = {PTR_W{1'b0}};
    end else begin
      ptr_next_s = win_r + PTR_W'(1);
    end
  end

  // Sequencer FSM: grant, execute/capture, done, back to idle.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {PTR_W{1'b0}};
      win_r       <= {PTR_W{1'b0}};
      gnt_r       <= {N_REQ{1'b0}};
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      err_r       <= 1'b0;
      alu_a_r     <= {WIDTH{1'b0}};
      alu_b_r     <= {WIDTH{1'b0}};
      alu_op_r    <= {OP_W{1'b0}};
      op_count_r  <= 8'd0;
      err_count_r <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            gnt_r    <= gnt_s;
            win_r    <= winner_s;
            alu_a_r  <= sel_a_s;
            alu_b_r  <= sel_b_s;
            alu_op_r <= sel_op_s;
            busy_r   <= 1'b1;
            state_r  <= ST_EXEC;
          end else begin
            state_r  <= ST_IDLE;
          end
        end
        ST_EXEC: begin
          result_r   <= bus.alu_result;
          err_r      <= bus.alu_err;
          done_r     <= 1'b1;
          op_count_r <= op_count_r + 8'd1;
          if (bus.alu_err && (err_count_r != 8'hFF)) begin
            err_count_r <= err_count_r + 8'd1;
          end else begin
            err_count_r <= err_count_r;
          end
          state_r    <= ST_DONE;
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          gnt_r   <= {N_REQ{1'b0}};
          busy_r  <= 1'b0;
          ptr_r   <= ptr_next_s;
          state_r <= ST_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          gnt_r   <= {N_REQ{1'b0}};
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.done      = done_r;
  assign bus.busy      = busy_r;
  assign bus.result    = result_r;
  assign bus.err       = err_r;
  assign bus.alu_a     = alu_a_r;
  assign bus.alu_b     = alu_b_r;
  assign bus.alu_op    = alu_op_r;
  assign bus.op_count  = op_count_r;
  assign bus.err_count = err_count_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small 6-bit ALU core model attached
// to the alu_* outputs.
module tb_alu_arbiter;

  logic clk;
  logic reset;

  alu_arbiter_if #(.N_REQ(4), .WIDTH(6), .OP_W(3)) bus ();

  alu_arbiter #(.N_REQ(4), .WIDTH(6), .OP_W(3)) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU core: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5..7 invalid
  logic [5:0] sum_s;
  logic [5:0] dif_s;
  always_comb begin
    sum_s = bus.alu_a + bus.alu_b;
    dif_s = bus.alu_a - bus.alu_b;
    bus.alu_result = 6'd0;
    bus.alu_err    = 1'b0;
    case (bus.alu_op)
      3'd0: begin
        bus.alu_result = sum_s;
        bus.alu_err    = (bus.alu_a[5] == bus.alu_b[5]) && (sum_s[5] != bus.alu_a[5]);
      end
      3'd1: begin
        bus.alu_result = dif_s;
        bus.alu_err    = (bus.alu_a[5] != bus.alu_b[5]) && (dif_s[5] != bus.alu_a[5]);
      end
      3'd2: bus.alu_result = bus.alu_a & bus.alu_b;
      3'd3: bus.alu_result = bus.alu_a | bus.alu_b;
      3'd4: bus.alu_result = bus.alu_a ^ bus.alu_b;
      default: begin
        bus.alu_result = 6'd0;
        bus.alu_err    = 1'b1;
      end
    endcase
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int         idx;
    logic [5:0] a;
    logic [5:0] b;
    logic [2:0] op;
    logic [3:0] gnt;
    logic [5:0] res;
    logic       er;
  } vec_t;

  vec_t tbl[8];
  int   exp_ops;
  int   exp_errs;

  task automatic set_fields(input int idx, input logic [5:0] a, input logic [5:0] b, input logic [2:0] op);
    bus.req_a[idx*6 +: 6]  = a;
    bus.req_b[idx*6 +: 6]  = b;
    bus.req_op[idx*3 +: 3] = op;
  endtask

  // One isolated operation from a single requester, checked cycle by cycle.
  task automatic do_op(input vec_t v);
    @(negedge clk);
    set_fields(v.idx, v.a, v.b, v.op);
    bus.req = 4'b0001 << v.idx;
    step();
    check("op_gnt", 32'(bus.gnt), 32'(v.gnt));
    check("op_busy", 32'(bus.busy), 32'd1);
    check("op_done_early", 32'(bus.done), 32'd0);
    check("op_alu_a", 32'(bus.alu_a), 32'(v.a));
    check("op_alu_op", 32'(bus.alu_op), 32'(v.op));
    step();
    bus.req = 4'b0000;
    exp_ops++;
    if (v.er) exp_errs++;
    check("op_done", 32'(bus.done), 32'd1);
    check("op_result", 32'(bus.result), 32'(v.res));
    check("op_err", 32'(bus.err), 32'(v.er));
    check("op_count", 32'(bus.op_count), 32'(exp_ops));
    check("op_err_count", 32'(bus.err_count), 32'(exp_errs));
    check("op_gnt_held", 32'(bus.gnt), 32'(v.gnt));
    step();
    check("op_done_end", 32'(bus.done), 32'd0);
    check("op_gnt_end", 32'(bus.gnt), 32'd0);
    check("op_busy_end", 32'(bus.busy), 32'd0);
    check("op_result_hold", 32'(bus.result), 32'(v.res));
  endtask

  // Single-cycle request; only the grant choice is of interest.
  task automatic serve(input logic [3:0] r, input logic [3:0] exp_gnt, input string nm);
    @(negedge clk);
    bus.req = r;
    step();
    check(nm, 32'(bus.gnt), 32'(exp_gnt));
    bus.req = 4'b0000;
    step();
    check({nm, "_done"}, 32'(bus.done), 32'd1);
    step();
    check({nm, "_idle"}, 32'(bus.gnt), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dones;
    logic [3:0] eg;

    tbl[0] = '{0, 6'b001001, 6'b001010, 3'd0, 4'b0001, 6'b010011, 1'b0};
    tbl[1] = '{2, 6'b010000, 6'b010111, 3'd0, 4'b0100, 6'b100111, 1'b1};
    tbl[2] = '{2, 6'b111100, 6'b001001, 3'd1, 4'b0100, 6'b110011, 1'b0};
    tbl[3] = '{1, 6'b101010, 6'b011100, 3'd2, 4'b0010, 6'b001000, 1'b0};
    tbl[4] = '{3, 6'b100000, 6'b000001, 3'd1, 4'b1000, 6'b011111, 1'b1};
    tbl[5] = '{1, 6'b000011, 6'b110000, 3'd3, 4'b0010, 6'b110011, 1'b0};
    tbl[6] = '{0, 6'b010101, 6'b001100, 3'd7, 4'b0001, 6'b000000, 1'b1};
    tbl[7] = '{3, 6'b111111, 6'b010101, 3'd4, 4'b1000, 6'b101010, 1'b0};

    reset      = 1'b1;
    bus.req    = 4'b0000;
    bus.req_a  = 24'd0;
    bus.req_b  = 24'd0;
    bus.req_op = 12'd0;
    exp_ops    = 0;
    exp_errs   = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_result", 32'(bus.result), 32'd0);
    check("rst_alu_a", 32'(bus.alu_a), 32'd0);
    check("rst_op_count", 32'(bus.op_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // table of isolated operations
    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i]);
    end

    // pointer now 0 (last served requester 3): 0101 held -> 0 then 2
    @(negedge clk);
    set_fields(0, 6'd1, 6'd1, 3'd0);
    set_fields(2, 6'd2, 6'd2, 3'd0);
    bus.req = 4'b0101;
    step();
    check("skip_first", 32'(bus.gnt), 32'b0001);
    step();
    check("skip_first_done", 32'(bus.done), 32'd1);
    check("skip_first_res", 32'(bus.result), 32'd2);
    step();
    check("skip_gap", 32'(bus.gnt), 32'd0);
    step();
    check("skip_second", 32'(bus.gnt), 32'b0100);
    bus.req = 4'b0000;
    step();
    check("skip_second_res", 32'(bus.result), 32'd4);
    step();
    // pointer 3, requester 0 only -> wrap
    serve(4'b0001, 4'b0001, "wrap_gnt");
    // pointer 1, requester 0 only
    serve(4'b0001, 4'b0001, "ptr1_req0");
    // pointer 1, requesters 0 and 1 -> 1 wins
    serve(4'b0011, 4'b0010, "ptr1_req01");

    // operand change and request withdrawal after the grant
    @(negedge clk);
    set_fields(1, 6'b000101, 6'b000011, 3'd0);
    bus.req = 4'b0010;
    step();
    check("stab_gnt", 32'(bus.gnt), 32'b0010);
    bus.req_a[6 +: 6] = 6'b010100;
    bus.req = 4'b0000;
    step();
    check("stab_done", 32'(bus.done), 32'd1);
    check("stab_result", 32'(bus.result), 32'b001000);
    check("stab_alu_a", 32'(bus.alu_a), 32'b000101);
    step();

    // reset in the middle of an operation
    @(negedge clk);
    bus.req = 4'b0100;
    step();
    check("mid_gnt", 32'(bus.gnt), 32'b0100);
    reset = 1'b1;
    #1;
    check("mid_rst_gnt", 32'(bus.gnt), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_ops", 32'(bus.op_count), 32'd0);
    check("mid_rst_errs", 32'(bus.err_count), 32'd0);
    check("mid_rst_alu_a", 32'(bus.alu_a), 32'd0);
    step();
    check("mid_rst_no_done", 32'(bus.done), 32'd0);

    // fairness with all requesting from reset release
    for (int i = 0; i < 4; i++) set_fields(i, 6'(i), 6'd1, 3'd0);
    bus.req = 4'b1111;
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 15; j++) begin
      step();
      eg = ((j % 3) < 2) ? (4'b0001 << ((j / 3) % 4)) : 4'b0000;
      check("fair_gnt", 32'(bus.gnt), 32'(eg));
      check("fair_done", 32'(bus.done), ((j % 3) == 1) ? 32'd1 : 32'd0);
    end

    // counter wrap and saturation with invalid-op (error) operations
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) set_fields(i, 6'd3, 6'd3, 3'd7);
    bus.req = 4'b1111;
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 1000 && dones < 260; c++) begin
      step();
      if (bus.done) begin
        dones++;
        if (dones == 255) begin
          check("cnt255_ops", 32'(bus.op_count), 32'd255);
          check("cnt255_errs", 32'(bus.err_count), 32'd255);
        end
        if (dones == 256) begin
          check("wrap_ops", 32'(bus.op_count), 32'd0);
          check("sat_errs_256", 32'(bus.err_count), 32'd255);
        end
        if (dones == 260) begin
          check("wrap_ops_260", 32'(bus.op_count), 32'd4);
          check("sat_errs_260", 32'(bus.err_count), 32'd255);
          bus.req = 4'b0000;
        end
      end
    end
    check("cnt_dones_seen", 32'(dones), 32'd260);
    step();
    step();
    check("cnt_idle_busy", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
